cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the 8-phase CPU.
- Owns the 3-bit phase counter and the CPU enable that drive the instruction controller.
- Provides run, halt, single-step and one PC breakpoint.
- Sits between the debug/test command source and the controller/datapath. Stops only at instruction boundaries, so the datapath is never frozen mid-instruction.

Parameters:
- AW, 5, PC/address width.
- CW, 16, completed-instruction counter width.
- AUTO_RUN, 0, 1 = leave reset in RUN instead of HALTED.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_run  input  1  start free-running (single-cycle pulse).
- cmd_halt  input  1  request stop at next instruction boundary (pulse).
- cmd_step  input  1  execute exactly one instruction (pulse).
- bp_en  input  1  breakpoint enable.
- bp_addr  input  AW  breakpoint PC.
- pc  input  AW  current PC from datapath.
- cpu_halt  input  1  controller halt output (HLT opcode).
- phase  output  3  instruction phase 0..7 to controller.
- cpu_en  output  1  datapath/controller clock enable.
- running  output  1  state is RUN or STEP.
- stop_cause  output  3  0 NONE, 1 CMD, 2 BREAK, 3 HLT, 4 STEP; valid while halted.
- stop_pulse  output  1  one-cycle pulse on entry to HALTED.
- instr_cnt  output  CW  completed instructions, saturating.

Behaviour:
- States: HALTED, RUN, STEP (2-bit encoding, defined in the package).
- Reset (sync, priority over everything):
  - state = HALTED (RUN if AUTO_RUN = 1).
  - phase = 0, instr_cnt = 0, stop_cause = NONE.
  - stop_pulse = 0, halt_pend = 0, hlt_pend = 0, resume = 0.
- Reset mid-instruction abandons the instruction; phase returns to 0.
- cpu_en is combinational: (state != HALTED) && !bp_hit.
  - bp_hit = bp_en && phase == 0 && pc == bp_addr && !resume && state == RUN.
- Phase advances by 1 on every cycle with cpu_en = 1, wrapping 7 -> 0. It holds otherwise.
- Boundary = cycle with cpu_en = 1 and phase == 7.
  - instr_cnt increments at each boundary and saturates at all-ones.
- HALTED, command priority cmd_step > cmd_run:
  - cmd_step -> STEP, resume = 1.
  - cmd_run -> RUN, resume = 1.
  - cmd_halt is ignored.
- RUN:
  - cmd_halt sets halt_pend. cmd_run and cmd_step are ignored.
  - cpu_halt sampled high while cpu_en = 1 sets hlt_pend.
  - At a boundary, checked in order:
    - hlt_pend -> HALTED, cause HLT.
    - halt_pend -> HALTED, cause CMD.
    - otherwise stay in RUN.
  - At every boundary: clear both pends and clear resume.
  - bp_hit -> HALTED in that cycle; phase stays 0; no instruction is executed; cause BREAK.
  - Simultaneous bp_hit and cmd_halt: BREAK wins.
- STEP:
  - Breakpoint is not checked (bp_hit is gated by RUN).
  - cmd_halt is ignored.
  - At the boundary -> HALTED, cause STEP, unless hlt_pend is set (then cause HLT). Clear resume and the pends.
- stop_pulse: asserted the cycle after any transition into HALTED, for one cycle only.
- stop_cause: holds until the next transition into HALTED. Set to NONE on leaving HALTED.
- Resume from a breakpoint with cmd_run executes the instruction at bp_addr. A break recurs only on the next arrival at bp_addr.
- Entry to HALTED always leaves phase == 0.

Decomposition:
- Package cpu_run_pkg holds:
  - run-state enum (HALTED, RUN, STEP);
  - stop_cause constants (CAUSE_NONE .. CAUSE_STEP);
  - PHASE_W = 3 and PHASE_LAST = 7.
- One natural sub-module: phase_counter (enable, sync clear, wrap flag at 7), reused by the controller bench.

Test Plan:
- Reset, then cmd_run at cycle 2 -> cpu_en = 1 from cycle 3; phase 0..7 repeats; instr_cnt = 3 after 24 enabled cycles.
- RUN, cmd_halt at phase 2 -> continues to phase 7, then HALTED with phase = 0, stop_cause = 1, stop_pulse one cycle; instr_cnt +1.
- HALTED, cmd_step -> exactly 8 enabled cycles, then HALTED, stop_cause = 4, instr_cnt +1. cmd_step plus cmd_run in the same cycle -> STEP.
- bp_en = 1, bp_addr = 5'h0A, RUN until pc = 0x0A at phase 0 -> cpu_en = 0 in that cycle, stop_cause = 2. cmd_run -> the instruction at 0x0A executes with no re-break.
- cpu_halt pulse at phase 4, plus cmd_halt at phase 5 -> stop at boundary with stop_cause = 3 (HLT over CMD).
- Reset asserted at phase 5 in RUN -> next cycle phase = 0, HALTED, instr_cnt = 0. Separately, force instr_cnt to all-ones (CW = 4 build) -> it stays at 15.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_pkg
// Description : Shared types and constants for the CPU run-control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } run_state_e;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_CMD   = 3'd1;
    localparam logic [2:0] CAUSE_BREAK = 3'd2;
    localparam logic [2:0] CAUSE_HLT   = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;

    localparam int                 PHASE_W    = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd7;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl_if
// Description : Command / status bundle between debug source and run control.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic          cmd_run;
    logic          cmd_halt;
    logic          cmd_step;
    logic          bp_en;
    logic [AW-1:0] bp_addr;
    logic [AW-1:0] pc;
    logic          cpu_halt;
    logic [2:0]    phase;
    logic          cpu_en;
    logic          running;
    logic [2:0]    stop_cause;
    logic          stop_pulse;
    logic [CW-1:0] instr_cnt;

    modport master (
        output cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc, cpu_halt,
        input  phase, cpu_en, running, stop_cause, stop_pulse, instr_cnt
    );

    modport slave (
        input  cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc, cpu_halt,
        output phase, cpu_en, running, stop_cause, stop_pulse, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Enabled 0..7 instruction phase counter with wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter
    import cpu_run_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_en,
    input  wire logic               i_clr,
    output logic      [PHASE_W-1:0] o_phase,
    output logic                    o_wrap
);
    logic [PHASE_W-1:0] r_phase;

    // Natural binary overflow provides the 7 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = (r_phase == PHASE_LAST);
endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run / halt / single-step / breakpoint sequencer for 8-phase CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int AW       = 5,
    parameter int CW       = 16,
    parameter bit AUTO_RUN = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cpu_run_ctrl_if.slave    bus
);
    localparam run_state_e c_RESET_STATE = AUTO_RUN ? ST_RUN : ST_HALTED;

    run_state_e         r_state, w_state_nxt;
    logic               r_halt_pend, w_halt_pend_nxt;
    logic               r_hlt_pend, w_hlt_pend_nxt;
    logic               r_resume, w_resume_nxt;
    logic [2:0]         r_stop_cause, w_stop_cause_nxt;
    logic               r_stop_pulse;
    logic [CW-1:0]      r_instr_cnt;
    logic               w_enter_halt;
    logic [PHASE_W-1:0] w_phase;
    logic               w_wrap;
    logic               w_bp_hit;
    logic               w_cpu_en;
    logic               w_boundary;
    logic               w_hlt_seen;
    logic               w_halt_seen;

    phase_counter u_phase (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cpu_en),
        .i_clr   (1'b0),
        .o_phase (w_phase),
        .o_wrap  (w_wrap)
    );

    // Resume masks the break so the instruction at bp_addr can execute once.
    assign w_bp_hit   = bus.bp_en && (w_phase == '0) && (bus.pc == bus.bp_addr)
                        && !r_resume && (r_state == ST_RUN);
    assign w_cpu_en   = (r_state != ST_HALTED) && !w_bp_hit;
    assign w_boundary = w_cpu_en && w_wrap;
    assign w_hlt_seen  = r_hlt_pend || (bus.cpu_halt && w_cpu_en);
    assign w_halt_seen = r_halt_pend || bus.cmd_halt;

    always_comb begin
        w_state_nxt      = r_state;
        w_halt_pend_nxt  = r_halt_pend;
        w_hlt_pend_nxt   = r_hlt_pend;
        w_resume_nxt     = r_resume;
        w_stop_cause_nxt = r_stop_cause;
        w_enter_halt     = 1'b0;
        case (r_state)
            ST_HALTED: begin
                if (bus.cmd_step) begin
                    w_state_nxt      = ST_STEP;
                    w_resume_nxt     = 1'b1;
                    w_stop_cause_nxt = CAUSE_NONE;
                end else if (bus.cmd_run) begin
                    w_state_nxt      = ST_RUN;
                    w_resume_nxt     = 1'b1;
                    w_stop_cause_nxt = CAUSE_NONE;
                end
            end
            ST_RUN: begin
                if (w_bp_hit) begin
                    w_state_nxt      = ST_HALTED;
                    w_stop_cause_nxt = CAUSE_BREAK;
                    w_halt_pend_nxt  = 1'b0;
                    w_hlt_pend_nxt   = 1'b0;
                    w_enter_halt     = 1'b1;
                end else if (w_boundary) begin
                    w_halt_pend_nxt = 1'b0;
                    w_hlt_pend_nxt  = 1'b0;
                    w_resume_nxt    = 1'b0;
                    if (w_hlt_seen) begin
                        w_state_nxt      = ST_HALTED;
                        w_stop_cause_nxt = CAUSE_HLT;
                        w_enter_halt     = 1'b1;
                    end else if (w_halt_seen) begin
                        w_state_nxt      = ST_HALTED;
                        w_stop_cause_nxt = CAUSE_CMD;
                        w_enter_halt     = 1'b1;
                    end
                end else begin
                    w_halt_pend_nxt = w_halt_seen;
                    w_hlt_pend_nxt  = w_hlt_seen;
                end
            end
            ST_STEP: begin
                if (w_boundary) begin
                    w_state_nxt      = ST_HALTED;
                    w_stop_cause_nxt = w_hlt_seen ? CAUSE_HLT : CAUSE_STEP;
                    w_halt_pend_nxt  = 1'b0;
                    w_hlt_pend_nxt   = 1'b0;
                    w_resume_nxt     = 1'b0;
                    w_enter_halt     = 1'b1;
                end else begin
                    w_hlt_pend_nxt = w_hlt_seen;
                end
            end
            default: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_RESET_STATE;
            r_halt_pend  <= 1'b0;
            r_hlt_pend   <= 1'b0;
            r_resume     <= 1'b0;
            r_stop_cause <= CAUSE_NONE;
            r_stop_pulse <= 1'b0;
            r_instr_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
            r_hlt_pend   <= w_hlt_pend_nxt;
            r_resume     <= w_resume_nxt;
            r_stop_cause <= w_stop_cause_nxt;
            r_stop_pulse <= w_enter_halt;
            if (w_boundary && (r_instr_cnt != {CW{1'b1}})) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign bus.phase      = w_phase;
    assign bus.cpu_en     = w_cpu_en;
    assign bus.running    = (r_state != ST_HALTED);
    assign bus.stop_cause = r_stop_cause;
    assign bus.stop_pulse = r_stop_pulse;
    assign bus.instr_cnt  = r_instr_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Directed self-checking bench for cpu_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   en_cnt;

    cpu_run_ctrl_if #(.AW(5), .CW(16)) bus  ();
    cpu_run_ctrl_if #(.AW(5), .CW(4))  bus2 ();

    cpu_run_ctrl #(.AW(5), .CW(16), .AUTO_RUN(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow counter, leaves reset already running.
    cpu_run_ctrl #(.AW(5), .CW(4), .AUTO_RUN(1'b1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.cmd_run = 1'b0;  bus.cmd_halt = 1'b0; bus.cmd_step = 1'b0;
        bus.bp_en   = 1'b0;  bus.bp_addr  = '0;   bus.pc       = '0;
        bus.cpu_halt = 1'b0;
        bus2.cmd_run = 1'b0; bus2.cmd_halt = 1'b0; bus2.cmd_step = 1'b0;
        bus2.bp_en   = 1'b0; bus2.bp_addr  = '0;   bus2.pc       = '0;
        bus2.cpu_halt = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_phase", 32'(bus.phase), 0);
        check("rst_cpu_en", 32'(bus.cpu_en), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_cause", 32'(bus.stop_cause), 0);
        check("rst_pulse", 32'(bus.stop_pulse), 0);
        check("rst_cnt", 32'(bus.instr_cnt), 0);

        // Free run: three full instructions
        bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0; #1;
        check("run_cpu_en", 32'(bus.cpu_en), 1);
        check("run_running", 32'(bus.running), 1);
        for (int i = 0; i < 24; i++) begin
            check("run_phase_seq", 32'(bus.phase), 32'(i % 8));
            cyc();
        end
        check("run_cnt3", 32'(bus.instr_cnt), 3);

        // cmd_halt at phase 2 stops at the boundary
        cyc(); cyc();
        check("halt_at_ph2", 32'(bus.phase), 2);
        bus.cmd_halt = 1'b1; cyc(); bus.cmd_halt = 1'b0;
        repeat (4) cyc();
        check("halt_ph7_still_en", 32'(bus.cpu_en), 1);
        cyc();
        check("halt_running", 32'(bus.running), 0);
        check("halt_phase0", 32'(bus.phase), 0);
        check("halt_cause_cmd", 32'(bus.stop_cause), 1);
        check("halt_pulse", 32'(bus.stop_pulse), 1);
        check("halt_cnt4", 32'(bus.instr_cnt), 4);
        cyc();
        check("halt_pulse_drop", 32'(bus.stop_pulse), 0);
        check("halt_cause_hold", 32'(bus.stop_cause), 1);

        // Single step, with cmd_run in the same cycle (step wins)
        bus.cmd_step = 1'b1; bus.cmd_run = 1'b1; cyc();
        bus.cmd_step = 1'b0; bus.cmd_run = 1'b0; #1;
        check("step_cause_none", 32'(bus.stop_cause), 0);
        en_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.cpu_en) break;
            en_cnt++;
            cyc();
        end
        check("step_en_cycles", 32'(en_cnt), 8);
        check("step_cause", 32'(bus.stop_cause), 4);
        check("step_cnt5", 32'(bus.instr_cnt), 5);
        check("step_pulse", 32'(bus.stop_pulse), 1);

        // Breakpoint at 0x0A
        bus.bp_en = 1'b1; bus.bp_addr = 5'h0A; bus.pc = 5'h08;
        bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0;
        repeat (8) cyc();
        bus.pc = 5'h09;
        repeat (8) cyc();
        bus.pc = 5'h0A; #1;
        check("bp_cpu_en_low", 32'(bus.cpu_en), 0);
        cyc();
        check("bp_running", 32'(bus.running), 0);
        check("bp_cause", 32'(bus.stop_cause), 2);
        check("bp_phase0", 32'(bus.phase), 0);
        check("bp_cnt7", 32'(bus.instr_cnt), 7);
        bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0; #1;
        check("bp_resume_en", 32'(bus.cpu_en), 1);
        repeat (8) cyc();
        check("bp_resume_cnt8", 32'(bus.instr_cnt), 8);
        bus.pc = 5'h0B; #1;
        check("bp_no_rebreak", 32'(bus.cpu_en), 1);
        bus.cmd_halt = 1'b1; cyc(); bus.cmd_halt = 1'b0;
        repeat (7) cyc();
        check("bp_exit_cause", 32'(bus.stop_cause), 1);
        check("bp_exit_cnt9", 32'(bus.instr_cnt), 9);
        bus.bp_en = 1'b0;

        // HLT at phase 4 beats cmd_halt at phase 5
        bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0;
        repeat (4) cyc();
        check("hlt_at_ph4", 32'(bus.phase), 4);
        bus.cpu_halt = 1'b1; cyc(); bus.cpu_halt = 1'b0;
        bus.cmd_halt = 1'b1; cyc(); bus.cmd_halt = 1'b0;
        cyc();
        check("hlt_not_yet", 32'(bus.running), 1);
        cyc();
        check("hlt_cause", 32'(bus.stop_cause), 3);
        check("hlt_running", 32'(bus.running), 0);
        check("hlt_cnt10", 32'(bus.instr_cnt), 10);

        // Reset mid-instruction
        bus.cmd_run = 1'b1; cyc(); bus.cmd_run = 1'b0;
        repeat (5) cyc();
        check("mid_rst_ph5", 32'(bus.phase), 5);
        rst = 1'b1; cyc();
        check("mid_rst_phase", 32'(bus.phase), 0);
        check("mid_rst_running", 32'(bus.running), 0);
        check("mid_rst_cnt", 32'(bus.instr_cnt), 0);
        check("mid_rst_cause", 32'(bus.stop_cause), 0);
        rst = 1'b0; #1;

        // Saturation on the 4-bit, auto-run instance
        check("sat_autorun", 32'(bus2.running), 1);
        check("sat_cpu_en", 32'(bus2.cpu_en), 1);
        check("sat_cnt0", 32'(bus2.instr_cnt), 0);
        repeat (120) cyc();
        check("sat_cnt15", 32'(bus2.instr_cnt), 15);
        repeat (16) cyc();
        check("sat_hold15", 32'(bus2.instr_cnt), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
